// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: write-back select encodings,
// load/store funct3 codes, FSM state encoding and access-size decode.
package mem_wb_stage_pkg;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_IMM  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Any funct3 that is not a legal code for the access direction is a word access.
  function automatic size_t access_size(input logic [2:0] funct3, input logic store);
    size_t sz;
    sz = SZ_WORD;
    if (store) begin
      if (funct3 == F3_SB) sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU) sz = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the MEM stage.
// Ports: funct3/store/addr_lo select size and lane; store_data -> wstrb/wdata
// (lane-replicated); rdata -> load_data (extracted and extended);
// misaligned flags half accesses on odd bytes and words off a word boundary.
module mem_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  size_t       size;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size       = access_size(funct3, store);
    wstrb      = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;

    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        // funct3[2] marks the unsigned load variants
        load_data = funct3[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = funct3[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase

    if (!store) wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB pipeline register of the RV32 core.
// Drives the data bus (req/ready handshake), aligns load/store data, selects
// the write-back value and registers it; stall_o holds upstream while a bus
// access is outstanding.
// Ports: clk/rst (async, active-high); EX/MEM inputs (*_i); data bus
// mem_*; stall_o; misalign_o; MEM/WB outputs have_inst_o, pc_o, rf_we_o,
// wR_o, wD_o.
// Build option: MEM_ALIGN_CHECK_EN suppresses misaligned half/word accesses
// and flags them on misalign_o instead.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              have_inst_i,
  input  logic [31:0]       pc_i,
  input  logic [1:0]        wd_sel_i,
  input  logic              rf_we_i,
  input  logic              dram_we_i,
  input  logic              dram_re_i,
  input  logic [2:0]        funct3_i,
  input  logic [DATA_W-1:0] alu_c_i,
  input  logic [DATA_W-1:0] rD2_i,
  input  logic [4:0]        wR_i,
  input  logic [31:0]       npc_pc4_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              have_inst_o,
  output logic [31:0]       pc_o,
  output logic              rf_we_o,
  output logic [4:0]        wR_o,
  output logic [DATA_W-1:0] wD_o
);

  state_t      state, state_n;
  logic        access, access_ok, mis_raw, mis_access, req;
  logic [3:0]  strb;
  logic [31:0] wdata, load_data, wd_next;

  mem_align u_align (
    .funct3     (funct3_i),
    .store      (dram_we_i),
    .addr_lo    (alu_c_i[1:0]),
    .store_data (rD2_i),
    .rdata      (mem_rdata_i),
    .wstrb      (strb),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (mis_raw)
  );

  assign access = have_inst_i & (dram_we_i | dram_re_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_access = access & mis_raw;
`else
  logic unused_mis;
  assign unused_mis = mis_raw;
  assign mis_access = 1'b0;
`endif
  assign access_ok = access & ~mis_access;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // FSM next state and bus request
  always_comb begin
    state_n = state;
    req     = 1'b0;
    case (state)
      ST_IDLE: begin
        req = access_ok;
        if (access_ok && !mem_ready_i) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        req = 1'b1;
        if (mem_ready_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Reset gating keeps the bus quiet while rst is held, even with an access presented.
  assign mem_req_o   = req & ~rst;
  assign stall_o     = mem_req_o & ~mem_ready_i;
  assign mem_we_o    = mem_req_o & dram_we_i;
  assign mem_addr_o  = ADDR_W'({alu_c_i[31:2], 2'b00});
  assign mem_wdata_o = wdata;
  assign mem_wstrb_o = mem_req_o ? strb : 4'b0000;

  // Write-back source select
  always_comb begin
    case (wd_sel_i)
      WD_ALU:  wd_next = alu_c_i;
      WD_DRAM: wd_next = load_data;
      WD_PC4:  wd_next = npc_pc4_i;
      default: wd_next = imm_i;
    endcase
  end

  // MEM/WB register; a stall cycle loads a bubble and holds the data fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_inst_o <= 1'b0;
      pc_o        <= '0;
      rf_we_o     <= 1'b0;
      wR_o        <= '0;
      wD_o        <= '0;
    end else if (stall_o) begin
      have_inst_o <= 1'b0;
      rf_we_o     <= 1'b0;
    end else begin
      have_inst_o <= have_inst_i;
      pc_o        <= pc_i;
      rf_we_o     <= rf_we_i & ~mis_access;
      wR_o        <= wR_i;
      wD_o        <= wd_next;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          misalign_o <= 1'b0;
    else if (stall_o) misalign_o <= 1'b0;
    else              misalign_o <= mis_access;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: stimulus pushes expected WB records,
// a negedge monitor pops and compares whenever have_inst_o is high.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        mis;
  } wb_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        have_inst_i = 1'b0, rf_we_i = 1'b0, dram_we_i = 1'b0, dram_re_i = 1'b0;
  logic [31:0] pc_i = '0, alu_c_i = '0, rD2_i = '0, npc_pc4_i = '0, imm_i = '0;
  logic [1:0]  wd_sel_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  wR_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_req_o, mem_we_o, stall_o, misalign_o, have_inst_o, rf_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, pc_o, wD_o;
  logic [3:0]  mem_wstrb_o;
  logic [4:0]  wR_o;

  int  checks = 0;
  int  errors = 0;
  wb_t exp_q[$];

  mem_wb_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .have_inst_i(have_inst_i), .pc_i(pc_i), .wd_sel_i(wd_sel_i),
    .rf_we_i(rf_we_i), .dram_we_i(dram_we_i), .dram_re_i(dram_re_i), .funct3_i(funct3_i),
    .alu_c_i(alu_c_i), .rD2_i(rD2_i), .wR_i(wR_i), .npc_pc4_i(npc_pc4_i), .imm_i(imm_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .misalign_o(misalign_o),
    .have_inst_o(have_inst_o), .pc_o(pc_o), .rf_we_o(rf_we_o), .wR_o(wR_o), .wD_o(wD_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid WB beat must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && have_inst_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_pc", pc_o, e.pc);
        chk("wb_rf_we", 32'(rf_we_o), 32'(e.rf_we));
        chk("wb_wR", 32'(wR_o), 32'(e.wr));
        chk("wb_wD", wD_o, e.wd);
        chk("wb_misalign", 32'(misalign_o), 32'(e.mis));
      end
    end
  end

  // Present one instruction at posedge+1 and play the bus side with `delay` wait cycles.
  task automatic issue(
    input logic [31:0] pc, input logic [1:0] wsel, input logic rfwe,
    input logic we, input logic re, input logic [2:0] f3,
    input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wr,
    input logic [31:0] pc4, input logic [31:0] imm,
    input int delay, input logic [31:0] rdata,
    input logic exp_req, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
    input logic [31:0] exp_wd, input logic exp_mis);
    wb_t e;
    have_inst_i = 1'b1; pc_i = pc; wd_sel_i = wsel; rf_we_i = rfwe;
    dram_we_i = we; dram_re_i = re; funct3_i = f3; alu_c_i = alu; rD2_i = rd2;
    wR_i = wr; npc_pc4_i = pc4; imm_i = imm;
    e.pc = pc; e.rf_we = rfwe & ~exp_mis; e.wr = wr; e.wd = exp_wd; e.mis = exp_mis;
    exp_q.push_back(e);
    if (exp_req) begin
      for (int k = 0; k < delay; k++) begin
        mem_ready_i = 1'b0;
        @(negedge clk);
        chk("wait_req", 32'(mem_req_o), 32'd1);
        chk("wait_stall", 32'(stall_o), 32'd1);
        chk("wait_addr", mem_addr_o, alu & 32'hFFFF_FFFC);
        if (k > 0) chk("wait_bubble", 32'(have_inst_o), 32'd0);
        @(posedge clk); #1;
      end
    end
    mem_ready_i = exp_req;
    mem_rdata_i = rdata;
    @(negedge clk);
    chk("req", 32'(mem_req_o), 32'(exp_req));
    chk("stall", 32'(stall_o), 32'd0);
    if (exp_req) begin
      chk("addr", mem_addr_o, alu & 32'hFFFF_FFFC);
      chk("we", 32'(mem_we_o), 32'(we));
      chk("wstrb", 32'(mem_wstrb_o), 32'(exp_strb));
      if (we) chk("wdata", mem_wdata_o, exp_wdata);
    end
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    have_inst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with an access presented: bus must stay quiet, outputs zero
    have_inst_i = 1'b1; dram_re_i = 1'b1;
    #2;
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_have", 32'(have_inst_o), 32'd0);
    chk("rst_wD", wD_o, 32'd0);
    have_inst_i = 1'b0; dram_re_i = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in WAIT: LW pending, no ready
    have_inst_i = 1'b1; pc_i = 32'h80; wd_sel_i = 2'd1; rf_we_i = 1'b1;
    dram_re_i = 1'b1; funct3_i = 3'b010; alu_c_i = 32'h1000; wR_i = 5'd3;
    mem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_req_pre", 32'(mem_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_req", 32'(mem_req_o), 32'd0);
    chk("rstw_stall", 32'(stall_o), 32'd0);
    chk("rstw_pc", pc_o, 32'd0);
    chk("rstw_wD", wD_o, 32'd0);
    have_inst_i = 1'b0; dram_re_i = 1'b0; rf_we_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_idle_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;

    // LW 0x1004 with two wait cycles
    issue(32'h100, 2'd1, 1, 0, 1, 3'b010, 32'h1004, 0, 5'd5, 0, 0, 2, 32'hDEADBEEF,
          1, 4'b0000, 0, 32'hDEADBEEF, 0);
    // SB 0x2003, immediate ready (back-to-back)
    issue(32'h104, 2'd0, 0, 1, 0, 3'b000, 32'h2003, 32'h000000A5, 5'd0, 0, 0, 0, 0,
          1, 4'b1000, 32'hA5A5A5A5, 32'h2003, 0);
    // SH 0x2002
    issue(32'h108, 2'd0, 0, 1, 0, 3'b001, 32'h2002, 32'h1234ABCD, 5'd0, 0, 0, 0, 0,
          1, 4'b1100, 32'hABCDABCD, 32'h2002, 0);
    // SW 0x2000, one wait cycle
    issue(32'h10C, 2'd0, 0, 1, 0, 3'b010, 32'h2000, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0,
          1, 4'b1111, 32'hCAFEF00D, 32'h2000, 0);
    // Loads from 0x3002, rdata 0x80F17F00
    issue(32'h110, 2'd1, 1, 0, 1, 3'b001, 32'h3002, 0, 5'd6, 0, 0, 0, 32'h80F17F00,
          1, 4'b0000, 0, 32'hFFFF80F1, 0);
    issue(32'h114, 2'd1, 1, 0, 1, 3'b101, 32'h3002, 0, 5'd7, 0, 0, 0, 32'h80F17F00,
          1, 4'b0000, 0, 32'h000080F1, 0);
    issue(32'h118, 2'd1, 1, 0, 1, 3'b000, 32'h3002, 0, 5'd8, 0, 0, 1, 32'h80F17F00,
          1, 4'b0000, 0, 32'hFFFFFFF1, 0);
    issue(32'h11C, 2'd1, 1, 0, 1, 3'b100, 32'h3002, 0, 5'd9, 0, 0, 0, 32'h80F17F00,
          1, 4'b0000, 0, 32'h000000F1, 0);
    issue(32'h120, 2'd1, 1, 0, 1, 3'b000, 32'h3001, 0, 5'd10, 0, 0, 0, 32'h80F17F00,
          1, 4'b0000, 0, 32'h0000007F, 0);
    // Unsupported funct3 on a load behaves as LW
    issue(32'h124, 2'd1, 1, 0, 1, 3'b011, 32'h1008, 0, 5'd11, 0, 0, 0, 32'h11223344,
          1, 4'b0000, 0, 32'h11223344, 0);
    // Non-access pass-through: PC4, IMM, ALU
    issue(32'h128, 2'd2, 1, 0, 0, 3'b000, 32'h77, 0, 5'd12, 32'h104, 32'h999, 0, 0,
          0, 4'b0000, 0, 32'h00000104, 0);
    issue(32'h12C, 2'd3, 1, 0, 0, 3'b000, 32'h77, 0, 5'd13, 32'h104, 32'h12345000, 0, 0,
          0, 4'b0000, 0, 32'h12345000, 0);
    issue(32'h130, 2'd0, 1, 0, 0, 3'b000, 32'h55, 0, 5'd14, 0, 0, 0, 0,
          0, 4'b0000, 0, 32'h00000055, 0);
`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned LW: no request, flagged, no register write
    issue(32'h134, 2'd1, 1, 0, 1, 3'b010, 32'h1002, 0, 5'd15, 0, 0, 0, 32'h01020304,
          0, 4'b0000, 0, 32'h01020304, 1);
`else
    // Without the check a misaligned LW reads the aligned word
    issue(32'h134, 2'd1, 1, 0, 1, 3'b010, 32'h1002, 0, 5'd15, 0, 0, 0, 32'h01020304,
          1, 4'b0000, 0, 32'h01020304, 0);
`endif
    // Ready while idle is ignored: no request, no output beat
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_ready_req", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
